// File: rtl/multi_timer.sv
// Multi-channel down-counting timer with per-channel CTRL/PRESET/COUNT registers and level IRQs.
// Optional feature: define MULTI_TIMER_PRESCALE_EN to enable the 8-bit per-channel prescaler in CTRL[15:8].
module multi_timer #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk_1,
    input  logic              reset,
    input  logic [3:0]        ADDR,
    input  logic              We,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic [NUM_CH-1:0] IRQ,
    output logic              IRQ_any
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t                   state_r   [NUM_CH];
    logic [CNT_W-1:0]         preset_r  [NUM_CH];
    logic [CNT_W-1:0]         count_r   [NUM_CH];
    logic [NUM_CH-1:0]        en_r;
    logic [NUM_CH-1:0][1:0]   mode_r;
    logic [NUM_CH-1:0]        im_r;
    logic [NUM_CH-1:0]        pend_r;
    logic [NUM_CH-1:0][7:0]   ps_r;
`ifdef MULTI_TIMER_PRESCALE_EN
    logic [NUM_CH-1:0][7:0]   pc_r;
`endif

    logic [NUM_CH-1:0]        wr_ctrl_s;
    logic [NUM_CH-1:0]        wr_preset_s;
    logic [NUM_CH-1:0]        tick_s;
    logic [31:0]              data_out_s;
    logic                     unused_s;

    assign unused_s = ^DataIn;

    // Write strobes per channel; out-of-range channels never match and are dropped.
    always_comb begin
        wr_ctrl_s   = {NUM_CH{1'b0}};
        wr_preset_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (We && (ADDR[3:2] == 2'(i))) begin
                wr_ctrl_s[i]   = (ADDR[1:0] == 2'd0);
                wr_preset_s[i] = (ADDR[1:0] == 2'd1);
            end else begin
                wr_ctrl_s[i]   = 1'b0;
                wr_preset_s[i] = 1'b0;
            end
        end
    end

    // Count enable: every CNT cycle, or once per PS+1 cycles with the prescaler built in.
    always_comb begin
        tick_s = {NUM_CH{1'b1}};
`ifdef MULTI_TIMER_PRESCALE_EN
        for (int i = 0; i < NUM_CH; i++) begin
            tick_s[i] = (pc_r[i] == ps_r[i]);
        end
`endif
    end

    // Per-channel register file and IDLE -> LOAD -> CNT -> INT sequencer.
    always_ff @(posedge clk_1) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i]  <= ST_IDLE;
                preset_r[i] <= {CNT_W{1'b0}};
                count_r[i]  <= {CNT_W{1'b0}};
            end
            en_r   <= {NUM_CH{1'b0}};
            mode_r <= {(2*NUM_CH){1'b0}};
            im_r   <= {NUM_CH{1'b0}};
            pend_r <= {NUM_CH{1'b0}};
            ps_r   <= {(8*NUM_CH){1'b0}};
`ifdef MULTI_TIMER_PRESCALE_EN
            pc_r   <= {(8*NUM_CH){1'b0}};
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_preset_s[i]) begin
                    preset_r[i] <= DataIn[CNT_W-1:0];
                end
                if (wr_ctrl_s[i]) begin
                    en_r[i]   <= DataIn[0];
                    mode_r[i] <= DataIn[2:1];
                    im_r[i]   <= DataIn[3];
`ifdef MULTI_TIMER_PRESCALE_EN
                    ps_r[i]   <= DataIn[15:8];
`endif
                    if (DataIn[4]) begin
                        pend_r[i] <= 1'b0;
                    end
                end
`ifdef MULTI_TIMER_PRESCALE_EN
                if ((state_r[i] == ST_CNT) && !tick_s[i]) begin
                    pc_r[i] <= pc_r[i] + 8'd1;
                end else begin
                    pc_r[i] <= 8'd0;
                end
`endif
                // Disabling wins over any state progress; COUNT keeps its last value.
                if (wr_ctrl_s[i] && !DataIn[0]) begin
                    state_r[i] <= ST_IDLE;
                end else begin
                    case (state_r[i])
                        ST_IDLE: begin
                            if (wr_ctrl_s[i] || en_r[i]) begin
                                state_r[i] <= ST_LOAD;
                            end
                        end
                        ST_LOAD: begin
                            count_r[i] <= preset_r[i];
                            state_r[i] <= ST_CNT;
                        end
                        ST_CNT: begin
                            if (tick_s[i]) begin
                                if (count_r[i] == {CNT_W{1'b0}}) begin
                                    pend_r[i]  <= 1'b1;
                                    state_r[i] <= ST_INT;
                                end else begin
                                    count_r[i] <= count_r[i] - CNT_W'(1);
                                end
                            end
                        end
                        ST_INT: begin
                            if (mode_r[i] == 2'b01) begin
                                state_r[i] <= ST_LOAD;
                            end else begin
                                en_r[i]    <= 1'b0;
                                state_r[i] <= ST_IDLE;
                            end
                        end
                        default: begin
                            state_r[i] <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // Read mux; unmatched channels and register 3 fall through to zero.
    always_comb begin
        data_out_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ADDR[3:2] == 2'(i)) begin
                case (ADDR[1:0])
                    2'd0:    data_out_s = {16'd0, ps_r[i], 3'd0, pend_r[i], im_r[i], mode_r[i], en_r[i]};
                    2'd1:    data_out_s = 32'(preset_r[i]);
                    2'd2:    data_out_s = 32'(count_r[i]);
                    default: data_out_s = 32'd0;
                endcase
            end else begin
                data_out_s = data_out_s;
            end
        end
    end

    assign DataOut = data_out_s;
    assign IRQ     = pend_r & im_r;
    assign IRQ_any = |(pend_r & im_r);

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (default 2x32 instance plus a 1x16 instance).
module tb_multi_timer;

    logic        clk_1 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ADDR = 4'd0;
    logic        We = 1'b0;
    logic [31:0] DataIn = 32'd0;
    logic [31:0] DataOut;
    logic [1:0]  IRQ;
    logic        IRQ_any;
    logic [31:0] data_out16;
    logic [0:0]  irq16;
    logic        irq_any16;
    logic [31:0] rd_v;

    int total = 0;
    int bad   = 0;

    multi_timer dut (
        .clk_1(clk_1), .reset(reset), .ADDR(ADDR), .We(We), .DataIn(DataIn),
        .DataOut(DataOut), .IRQ(IRQ), .IRQ_any(IRQ_any)
    );

    multi_timer #(.NUM_CH(1), .CNT_W(16)) dut16 (
        .clk_1(clk_1), .reset(reset), .ADDR(ADDR), .We(We), .DataIn(DataIn),
        .DataOut(data_out16), .IRQ(irq16), .IRQ_any(irq_any16)
    );

    always #5 clk_1 = ~clk_1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One write consumes exactly one rising edge; returns 1 time unit after it.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk_1);
        ADDR = a; We = 1'b1; DataIn = d;
        @(posedge clk_1); #1;
        We = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_1);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        ADDR = a; #1;
        d = DataOut;
    endtask

    initial begin
        tick(3);
        @(negedge clk_1); reset = 1'b0;
        tick(1);
        rd(4'h0, rd_v);           chk("rst_ctrl0", rd_v, 32'h0);
        chk("rst_irq", {30'd0, IRQ}, 32'h0);
        chk("rst_irq_any", {31'd0, IRQ_any}, 32'h0);

        // One-shot ch0, P=5: PEND on the 7th edge after enable
        wr(4'h1, 32'd5);
        wr(4'h0, 32'h9);
        tick(6);
        chk("os_irq_early", {30'd0, IRQ}, 32'h0);
        tick(1);
        chk("os_irq", {30'd0, IRQ}, 32'h1);
        chk("os_irq_any", {31'd0, IRQ_any}, 32'h1);
        rd(4'h0, rd_v);           chk("os_ctrl_int", rd_v, 32'h19);
        rd(4'h2, rd_v);           chk("os_count", rd_v, 32'h0);
        tick(1);
        rd(4'h0, rd_v);           chk("os_en_clr", rd_v, 32'h18);
        wr(4'h0, 32'h18);
        rd(4'h0, rd_v);           chk("os_w1c", rd_v, 32'h08);
        chk("os_irq_clr", {30'd0, IRQ}, 32'h0);

        // Auto-reload ch1, P=3: period 6; W1C on the set edge loses
        wr(4'h5, 32'd3);
        wr(4'h4, 32'hB);
        tick(4);
        chk("ar_irq_early", {30'd0, IRQ}, 32'h0);
        tick(1);
        chk("ar_irq1", {30'd0, IRQ}, 32'h2);
        wr(4'h4, 32'h1B);
        chk("ar_w1c", {30'd0, IRQ}, 32'h0);
        tick(4);
        chk("ar_irq_gap", {30'd0, IRQ}, 32'h0);
        wr(4'h4, 32'h1B);
        chk("ar_set_wins", {30'd0, IRQ}, 32'h2);
        rd(4'h4, rd_v);           chk("ar_ctrl", rd_v, 32'h1B);
        wr(4'h4, 32'h10);
        chk("ar_off_any", {31'd0, IRQ_any}, 32'h0);

        // Disable mid-count freezes COUNT; re-enable reloads the new PRESET
        wr(4'h1, 32'd20);
        wr(4'h0, 32'h1);
        tick(11);
        rd(4'h2, rd_v);           chk("dis_cnt10", rd_v, 32'd10);
        wr(4'h0, 32'h0);
        rd(4'h2, rd_v);           chk("dis_held", rd_v, 32'd10);
        tick(3);
        rd(4'h2, rd_v);           chk("dis_still", rd_v, 32'd10);
        chk("dis_no_irq", {31'd0, IRQ_any}, 32'h0);
        wr(4'h1, 32'd7);
        wr(4'h0, 32'h1);
        tick(1);
        rd(4'h2, rd_v);           chk("reen_reload", rd_v, 32'd7);
        wr(4'h0, 32'h0);
        rd(4'h2, rd_v);           chk("reen_held", rd_v, 32'd7);
        wr(4'h2, 32'h55);
        rd(4'h2, rd_v);           chk("count_ro", rd_v, 32'd7);

        // Decode boundaries, PRESET truncation, unused CTRL bits
        rd(4'hC, rd_v);           chk("oob_rd", rd_v, 32'h0);
        wr(4'hC, 32'hFFFF_FFFF);
        rd(4'hC, rd_v);           chk("oob_wr", rd_v, 32'h0);
        rd(4'h3, rd_v);           chk("reg3_rd", rd_v, 32'h0);
        wr(4'h1, 32'hFFFF_FFFF);
        rd(4'h1, rd_v);           chk("preset32", rd_v, 32'hFFFF_FFFF);
        chk("preset16", data_out16, 32'h0000_FFFF);
        wr(4'h0, 32'hFFFF_FF00);
        rd(4'h0, rd_v);           chk("ctrl_unused", rd_v, 32'h0);
        rd(4'h4, rd_v);
        chk("oob16_rd", data_out16, 32'h0);

        // Reset mid-count with a simultaneous PRESET write
        wr(4'h1, 32'd8);
        wr(4'h0, 32'h9);
        tick(5);
        rd(4'h2, rd_v);           chk("pre_rst_cnt", rd_v, 32'd4);
        @(negedge clk_1);
        reset = 1'b1; ADDR = 4'h1; We = 1'b1; DataIn = 32'h33;
        @(posedge clk_1); #1;
        We = 1'b0; reset = 1'b0;
        rd(4'h0, rd_v);           chk("rst_ctrl", rd_v, 32'h0);
        rd(4'h1, rd_v);           chk("rst_preset", rd_v, 32'h0);
        rd(4'h2, rd_v);           chk("rst_count", rd_v, 32'h0);
        chk("rst_irq2", {30'd0, IRQ}, 32'h0);
        tick(3);
        rd(4'h5, rd_v);           chk("rst_preset1", rd_v, 32'h0);
        rd(4'h2, rd_v);           chk("rst_idle_cnt", rd_v, 32'h0);
        chk("rst_idle_any", {31'd0, IRQ_any}, 32'h0);

        // P=0 on ch1: PEND 2 edges after enable
        wr(4'h5, 32'd0);
        wr(4'h4, 32'h9);
        tick(1);
        chk("p0_early", {30'd0, IRQ}, 32'h0);
        tick(1);
        chk("p0_irq", {30'd0, IRQ}, 32'h2);
        tick(1);
        rd(4'h4, rd_v);           chk("p0_ctrl", rd_v, 32'h18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
